// File: rtl/pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program sequencer:
//   seq_state_t     - run/halt/memory-wait state encoding
//   npc_sel_t       - next-PC source select
//   wait_cnt_width  - width of the memory wait counter for a given latency
// ----------------------------------------------------------------------------
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        sIDLE,
        sRUN,
        sMEMWAIT,
        sHALT
    } seq_state_t;

    typedef enum logic [2:0] {
        kNPC_INC,
        kNPC_REL,
        kNPC_ABS,
        kNPC_POP,
        kNPC_HOLD
    } npc_sel_t;

    localparam int CYCLE_CNT_W = 16;

    // The counter only ever holds values up to MEM_LAT-1; keep it at least
    // one bit wide so the zero-latency build still elaborates cleanly.
    function automatic int wait_cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// ----------------------------------------------------------------------------
// ret_stack
// LIFO return-address stack with a top-of-stack count pointer.
//   clk, rst_n : clock, asynchronous active-low reset (empties the stack)
//   clr        : synchronous flush to empty
//   push, din  : push din (ignored when full)
//   pop        : pop top entry (ignored when empty)
//   dout       : current top entry, valid whenever empty=0
//   full/empty : occupancy status
// ----------------------------------------------------------------------------
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_reg [DEPTH];
    logic [PTR_W:0]   cnt_reg;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] top_idx;
    logic             do_push;

    assign full    = (cnt_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (cnt_reg == '0);
    assign do_push = push && !full;
    assign wr_idx  = cnt_reg[PTR_W-1:0];
    // When empty this index wraps to DEPTH-1; dout is don't-care then.
    assign top_idx = cnt_reg[PTR_W-1:0] - PTR_W'(1);
    // The popped address must be usable in the same cycle, so the top entry
    // is read combinationally from the small register file.
    assign dout    = mem_reg[top_idx];

    // Entry storage needs no reset: only the count decides what is valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_idx == PTR_W'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (do_push) begin
            cnt_reg <= cnt_reg + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            cnt_reg <= cnt_reg - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Multi-cycle program sequencer: owns the PC, the run/halt FSM, memory
// access stall timing and the CALL/RET return-address stack.
// Optional feature macro: PC_SEQUENCER_CYCLE_COUNT_EN (enables CYCLE_CNT;
// otherwise CYCLE_CNT is tied to 0 and no counter flops exist).
// Ports:
//   CLK, RST_N            : clock, asynchronous active-low reset
//   START                 : single-cycle run request (IDLE/HALT only)
//   HALT_REQ              : current instruction is HALT
//   CTRL_branch_rel_z/nz  : conditional relative branch strobes
//   CTRL_branch_abs       : absolute jump, qualified by IS_CALL / IS_RET
//   CTRL_read/write_mem   : memory access in progress
//   ZERO                  : ALU zero flag
//   REL_OFFSET            : signed branch offset
//   ABS_TARGET            : absolute jump target
//   PC                    : current instruction address
//   DONE                  : 1 when not executing
//   STALL                 : hold pipeline/register writes this cycle
//   STK_OVF / STK_UNF     : sticky stack overflow / underflow
//   CYCLE_CNT             : saturating executed-cycle count
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4,
    parameter int MEM_LAT     = 1,
    parameter int START_ADDR  = 0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            HALT_REQ,
    input  logic            CTRL_branch_rel_z,
    input  logic            CTRL_branch_rel_nz,
    input  logic            CTRL_branch_abs,
    input  logic            IS_CALL,
    input  logic            IS_RET,
    input  logic            CTRL_read_mem,
    input  logic            CTRL_write_mem,
    input  logic            ZERO,
    input  logic [PC_W-1:0] REL_OFFSET,
    input  logic [PC_W-1:0] ABS_TARGET,
    output logic [PC_W-1:0] PC,
    output logic            DONE,
    output logic            STALL,
    output logic            STK_OVF,
    output logic            STK_UNF,
    output logic [15:0]     CYCLE_CNT
);

    localparam int WAIT_W = wait_cnt_width(MEM_LAT);

    seq_state_t        state_reg, state_next;
    npc_sel_t          npc_sel;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic              ovf_reg, ovf_next;
    logic              unf_reg, unf_next;
    logic              run_start;
    logic              stall;
    logic              done;
    logic              mem_op;
    logic              rel_taken;

    logic              stk_push, stk_pop, stk_clr;
    logic [PC_W-1:0]   stk_dout;
    logic              stk_full, stk_empty;

    assign mem_op    = CTRL_read_mem | CTRL_write_mem;
    assign rel_taken = (CTRL_branch_rel_z & ZERO) | (CTRL_branch_rel_nz & ~ZERO);

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (stk_clr),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_reg + PC_W'(1)),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next-state, next-PC select, stack strobes and status outputs.
    always_comb begin
        state_next = state_reg;
        npc_sel    = kNPC_HOLD;
        wait_next  = wait_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_clr    = 1'b0;
        run_start  = 1'b0;
        stall      = 1'b0;
        done       = 1'b0;

        unique case (state_reg)
            sIDLE, sHALT: begin
                done = 1'b1;
                if (START) begin
                    state_next = sRUN;
                    run_start  = 1'b1;
                    ovf_next   = 1'b0;
                    unf_next   = 1'b0;
                    stk_clr    = 1'b1;
                end
            end
            sRUN: begin
                if (HALT_REQ) begin
                    state_next = sHALT;
                end else if (mem_op && (MEM_LAT > 0)) begin
                    // This cycle is the first of the MEM_LAT stall cycles.
                    state_next = sMEMWAIT;
                    wait_next  = WAIT_W'(MEM_LAT - 1);
                    stall      = 1'b1;
                end else if (CTRL_branch_abs && IS_RET) begin
                    if (stk_empty) begin
                        unf_next = 1'b1;
                        npc_sel  = kNPC_INC;
                    end else begin
                        stk_pop = 1'b1;
                        npc_sel = kNPC_POP;
                    end
                end else if (CTRL_branch_abs && IS_CALL) begin
                    // A full stack drops the return address but still jumps.
                    npc_sel = kNPC_ABS;
                    if (stk_full) begin
                        ovf_next = 1'b1;
                    end else begin
                        stk_push = 1'b1;
                    end
                end else if (CTRL_branch_abs) begin
                    npc_sel = kNPC_ABS;
                end else if (rel_taken) begin
                    npc_sel = kNPC_REL;
                end else begin
                    npc_sel = kNPC_INC;
                end
            end
            sMEMWAIT: begin
                if (wait_reg == '0) begin
                    npc_sel    = kNPC_INC;
                    state_next = sRUN;
                end else begin
                    stall     = 1'b1;
                    wait_next = wait_reg - WAIT_W'(1);
                end
            end
            default: begin
                state_next = sIDLE;
            end
        endcase
    end

    // All PC arithmetic wraps modulo 2^PC_W; REL_OFFSET is two's complement.
    always_comb begin
        unique case (npc_sel)
            kNPC_INC: pc_next = pc_reg + PC_W'(1);
            kNPC_REL: pc_next = pc_reg + REL_OFFSET;
            kNPC_ABS: pc_next = ABS_TARGET;
            kNPC_POP: pc_next = stk_dout;
            default:  pc_next = pc_reg;
        endcase
        if (run_start) begin
            pc_next = PC_W'(START_ADDR);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= sIDLE;
            pc_reg    <= PC_W'(START_ADDR);
            wait_reg  <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            wait_reg  <= wait_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

`ifdef PC_SEQUENCER_CYCLE_COUNT_EN
    logic [CYCLE_CNT_W-1:0] cyc_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cyc_reg <= '0;
        end else if (run_start) begin
            cyc_reg <= '0;
        end else if (((state_reg == sRUN) || (state_reg == sMEMWAIT)) &&
                     (cyc_reg != {CYCLE_CNT_W{1'b1}})) begin
            cyc_reg <= cyc_reg + CYCLE_CNT_W'(1);
        end
    end

    assign CYCLE_CNT = cyc_reg;
`else
    assign CYCLE_CNT = '0;
`endif

    assign PC      = pc_reg;
    assign DONE    = done;
    assign STALL   = stall;
    assign STK_OVF = ovf_reg;
    assign STK_UNF = unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed, table-driven bench for pc_sequencer (PC_W=10, STACK_DEPTH=4,
// MEM_LAT=2). Each table row is one instruction cycle: the opcode is turned
// into control strobes, STALL is checked within the cycle, and PC/DONE/flags
// are checked just after the clock edge. Hand-written sequences cover reset
// during a memory wait and the cycle counter.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    typedef enum int {
        OP_NOP, OP_START, OP_HALT, OP_HALTX, OP_J, OP_CALL, OP_RET,
        OP_LD, OP_ST, OP_BZ, OP_BNZ
    } op_t;

    typedef struct {
        op_t        op;
        logic       zero;
        logic [9:0] arg;
        logic       e_stall;
        logic [9:0] e_pc;
        logic       e_done;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    logic       CLK;
    logic       RST_N;
    logic       START, HALT_REQ;
    logic       CTRL_branch_rel_z, CTRL_branch_rel_nz, CTRL_branch_abs;
    logic       IS_CALL, IS_RET, CTRL_read_mem, CTRL_write_mem, ZERO;
    logic [9:0] REL_OFFSET, ABS_TARGET;
    logic [9:0] PC;
    logic       DONE, STALL, STK_OVF, STK_UNF;
    logic [15:0] CYCLE_CNT;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    pc_sequencer #(
        .PC_W        (10),
        .STACK_DEPTH (4),
        .MEM_LAT     (2),
        .START_ADDR  (0)
    ) dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .START              (START),
        .HALT_REQ           (HALT_REQ),
        .CTRL_branch_rel_z  (CTRL_branch_rel_z),
        .CTRL_branch_rel_nz (CTRL_branch_rel_nz),
        .CTRL_branch_abs    (CTRL_branch_abs),
        .IS_CALL            (IS_CALL),
        .IS_RET             (IS_RET),
        .CTRL_read_mem      (CTRL_read_mem),
        .CTRL_write_mem     (CTRL_write_mem),
        .ZERO               (ZERO),
        .REL_OFFSET         (REL_OFFSET),
        .ABS_TARGET         (ABS_TARGET),
        .PC                 (PC),
        .DONE               (DONE),
        .STALL              (STALL),
        .STK_OVF            (STK_OVF),
        .STK_UNF            (STK_UNF),
        .CYCLE_CNT          (CYCLE_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(op_t op, logic z, logic [9:0] arg, logic st,
                                logic [9:0] pc, logic dn, logic ov, logic un);
        vec_t v;
        v.op = op; v.zero = z; v.arg = arg; v.e_stall = st;
        v.e_pc = pc; v.e_done = dn; v.e_ovf = ov; v.e_unf = un;
        vecs.push_back(v);
    endfunction

    task automatic drive(input op_t op, input logic z, input logic [9:0] arg);
        START = 0; HALT_REQ = 0; CTRL_branch_rel_z = 0; CTRL_branch_rel_nz = 0;
        CTRL_branch_abs = 0; IS_CALL = 0; IS_RET = 0; CTRL_read_mem = 0;
        CTRL_write_mem = 0; ZERO = z; REL_OFFSET = arg; ABS_TARGET = arg;
        case (op)
            OP_START: START = 1;
            OP_HALT:  HALT_REQ = 1;
            OP_HALTX: begin
                HALT_REQ = 1; CTRL_branch_abs = 1; IS_CALL = 1; CTRL_read_mem = 1;
            end
            OP_J:     CTRL_branch_abs = 1;
            OP_CALL:  begin CTRL_branch_abs = 1; IS_CALL = 1; end
            OP_RET:   begin CTRL_branch_abs = 1; IS_RET = 1; end
            OP_LD:    CTRL_read_mem = 1;
            OP_ST:    CTRL_write_mem = 1;
            OP_BZ:    CTRL_branch_rel_z = 1;
            OP_BNZ:   CTRL_branch_rel_nz = 1;
            default:  ;
        endcase
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [15:0] exp_cnt;

        // ---------------- vector table ----------------
        //   op        z  arg     stall pc      done ovf unf
        add(OP_START, 0, 10'h000, 0, 10'h000, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(OP_NOP, 0, 0, 0, 10'(i), 0, 0, 0);
        add(OP_HALT,  0, 10'h000, 0, 10'h005, 1, 0, 0);
        add(OP_NOP,   0, 10'h000, 0, 10'h005, 1, 0, 0);
        add(OP_START, 0, 10'h000, 0, 10'h000, 0, 0, 0);
        for (int i = 1; i <= 3; i++) add(OP_NOP, 0, 0, 0, 10'(i), 0, 0, 0);
        add(OP_LD,    0, 10'h000, 1, 10'h003, 0, 0, 0);
        add(OP_NOP,   0, 10'h000, 1, 10'h003, 0, 0, 0);
        add(OP_NOP,   0, 10'h000, 0, 10'h004, 0, 0, 0);
        add(OP_ST,    0, 10'h000, 1, 10'h004, 0, 0, 0);
        add(OP_NOP,   0, 10'h000, 1, 10'h004, 0, 0, 0);
        add(OP_NOP,   0, 10'h000, 0, 10'h005, 0, 0, 0);
        add(OP_START, 0, 10'h000, 0, 10'h006, 0, 0, 0);  // ignored in RUN
        add(OP_J,     0, 10'h007, 0, 10'h007, 0, 0, 0);
        add(OP_CALL,  0, 10'h040, 0, 10'h040, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(OP_NOP, 0, 0, 0, 10'(10'h040 + i), 0, 0, 0);
        add(OP_RET,   0, 10'h000, 0, 10'h008, 0, 0, 0);
        add(OP_J,     0, 10'h00A, 0, 10'h00A, 0, 0, 0);
        add(OP_BZ,    1, 10'h3FD, 0, 10'h007, 0, 0, 0);  // 10 + (-3)
        add(OP_J,     0, 10'h00A, 0, 10'h00A, 0, 0, 0);
        add(OP_BNZ,   1, 10'h3FD, 0, 10'h00B, 0, 0, 0);  // not taken
        add(OP_BNZ,   0, 10'h005, 0, 10'h010, 0, 0, 0);  // taken
        add(OP_BZ,    0, 10'h005, 0, 10'h011, 0, 0, 0);  // not taken
        add(OP_J,     0, 10'h3FF, 0, 10'h3FF, 0, 0, 0);
        add(OP_NOP,   0, 10'h000, 0, 10'h000, 0, 0, 0);  // wrap
        add(OP_CALL,  0, 10'h100, 0, 10'h100, 0, 0, 0);
        add(OP_CALL,  0, 10'h200, 0, 10'h200, 0, 0, 0);
        add(OP_CALL,  0, 10'h300, 0, 10'h300, 0, 0, 0);
        add(OP_CALL,  0, 10'h050, 0, 10'h050, 0, 0, 0);
        add(OP_CALL,  0, 10'h060, 0, 10'h060, 0, 1, 0);  // overflow, jump taken
        add(OP_RET,   0, 10'h000, 0, 10'h301, 0, 1, 0);
        add(OP_RET,   0, 10'h000, 0, 10'h201, 0, 1, 0);
        add(OP_RET,   0, 10'h000, 0, 10'h101, 0, 1, 0);
        add(OP_RET,   0, 10'h000, 0, 10'h001, 0, 1, 0);
        add(OP_RET,   0, 10'h000, 0, 10'h002, 0, 1, 1);  // underflow, PC+1
        add(OP_NOP,   0, 10'h000, 0, 10'h003, 0, 1, 1);
        add(OP_HALT,  0, 10'h000, 0, 10'h003, 1, 1, 1);
        add(OP_START, 0, 10'h000, 0, 10'h000, 0, 0, 0);  // flags cleared
        add(OP_NOP,   0, 10'h000, 0, 10'h001, 0, 0, 0);
        add(OP_HALTX, 0, 10'h123, 0, 10'h001, 1, 0, 0);  // HALT beats jump/load

        // ---------------- reset state ----------------
        drive(OP_NOP, 0, 0);
        RST_N = 1'b0;
        step();
        step();
        chk("reset_pc",    16'(PC), 16'h000);
        chk("reset_done",  16'(DONE), 16'h1);
        chk("reset_stall", 16'(STALL), 16'h0);
        chk("reset_ovf",   16'(STK_OVF), 16'h0);
        chk("reset_unf",   16'(STK_UNF), 16'h0);
        chk("reset_cnt",   CYCLE_CNT, 16'h0);
        RST_N = 1'b1;
        step();

        // ---------------- table loop ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].zero, vecs[i].arg);
            #1;
            chk($sformatf("v%0d_stall", i), 16'(STALL), 16'(vecs[i].e_stall));
            step();
            chk($sformatf("v%0d_pc", i),   16'(PC),      16'(vecs[i].e_pc));
            chk($sformatf("v%0d_done", i), 16'(DONE),    16'(vecs[i].e_done));
            chk($sformatf("v%0d_ovf", i),  16'(STK_OVF), 16'(vecs[i].e_ovf));
            chk($sformatf("v%0d_unf", i),  16'(STK_UNF), 16'(vecs[i].e_unf));
            $display("vec %0d op=%0d pc=%03h done=%0b stall_exp=%0b ovf=%0b unf=%0b",
                     i, vecs[i].op, PC, DONE, vecs[i].e_stall, STK_OVF, STK_UNF);
        end

        // ---------------- reset during MEMWAIT ----------------
        drive(OP_START, 0, 0);           step();
        drive(OP_NOP, 0, 0);             step();
        drive(OP_NOP, 0, 0);             step();
        drive(OP_CALL, 0, 10'h020);      step();
        chk("seq_call_pc", 16'(PC), 16'h020);
        drive(OP_LD, 0, 0);
        #1;
        chk("seq_ld_stall", 16'(STALL), 16'h1);
        step();
        drive(OP_NOP, 0, 0);
        #1;
        chk("seq_wait_stall", 16'(STALL), 16'h1);
        chk("seq_wait_pc",    16'(PC), 16'h020);
`ifdef PC_SEQUENCER_CYCLE_COUNT_EN
        exp_cnt = 16'd4;
`else
        exp_cnt = 16'd0;
`endif
        chk("seq_cycle_cnt", CYCLE_CNT, exp_cnt);
        $display("seq memwait pc=%03h stall=%0b cnt=%0d", PC, STALL, CYCLE_CNT);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_pc",    16'(PC), 16'h000);
        chk("arst_done",  16'(DONE), 16'h1);
        chk("arst_stall", 16'(STALL), 16'h0);
        chk("arst_cnt",   CYCLE_CNT, 16'h0);
        $display("seq async reset pc=%03h done=%0b stall=%0b", PC, DONE, STALL);
        step();
        step();
        RST_N = 1'b1;
        drive(OP_START, 0, 0);           step();
        chk("rst_start_pc",   16'(PC), 16'h000);
        chk("rst_start_done", 16'(DONE), 16'h0);
        drive(OP_RET, 0, 0);             step();
        chk("rst_ret_pc",  16'(PC), 16'h001);
        chk("rst_ret_unf", 16'(STK_UNF), 16'h1);
        $display("seq restart ret pc=%03h unf=%0b", PC, STK_UNF);
        drive(OP_NOP, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
